// File: rtl/dft_frame_driver_if.sv
// rtl/dft_frame_driver_if.sv - start, sample stream, DFT core and result signals of the frame driver
interface dft_frame_driver_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] start_k;
  logic [WIDTH-1:0] start_len;

  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  logic [WIDTH-1:0] core_x;
  logic             core_wr;
  logic [WIDTH-1:0] core_n;
  logic [WIDTH-1:0] core_k;
  logic [WIDTH-1:0] core_len;
  logic             core_rst;
  logic [WIDTH-1:0] core_re;
  logic [WIDTH-1:0] core_im;
  logic             core_done;

  logic [WIDTH-1:0] res_re;
  logic [WIDTH-1:0] res_im;
  logic             res_valid;
  logic             res_ready;

  logic             busy;
  logic             err;

  modport master (
    input  start, start_k, start_len, s_data, s_valid, core_re, core_im, core_done, res_ready,
    output s_ready, core_x, core_wr, core_n, core_k, core_len, core_rst,
           res_re, res_im, res_valid, busy, err
  );

  modport slave (
    output start, start_k, start_len, s_data, s_valid, core_re, core_im, core_done, res_ready,
    input  s_ready, core_x, core_wr, core_n, core_k, core_len, core_rst,
           res_re, res_im, res_valid, busy, err
  );
endinterface

// File: rtl/dft_frame_driver.sv
// rtl/dft_frame_driver.sv - feeds one frame of samples into the single-bin DFT core and returns its scaled result
module dft_frame_driver #(
  parameter int WIDTH     = 16,
  parameter int N_MAX     = 1024,
  parameter int LOG_N_MAX = 10,
  parameter int FRAC_BITS = 6,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  dft_frame_driver_if.master   bus
);

  localparam int               TW     = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] NMAX_W = WIDTH'(N_MAX);

  typedef enum logic [2:0] {S_IDLE, S_CRST, S_LOAD, S_WAIT, S_HOLD} state_t;

  state_t               state;
  logic [LOG_N_MAX-1:0] count;
  logic [TW-1:0]        timer;
  logic                 len_ok;
  logic                 last;

  assign len_ok = (bus.start_len != '0) && (bus.start_len <= NMAX_W);
  assign last   = (WIDTH'(count) == bus.core_len - WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      count         <= '0;
      timer         <= '0;
      bus.s_ready   <= 1'b0;
      bus.core_x    <= '0;
      bus.core_wr   <= 1'b0;
      bus.core_n    <= '0;
      bus.core_k    <= '0;
      bus.core_len  <= '0;
      bus.core_rst  <= 1'b0;
      bus.res_re    <= '0;
      bus.res_im    <= '0;
      bus.res_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.err      <= 1'b0;
      bus.core_rst <= 1'b0;
      bus.core_wr  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (len_ok) begin
              bus.core_k   <= bus.start_k;
              bus.core_len <= bus.start_len;
              bus.core_rst <= 1'b1;
              bus.busy     <= 1'b1;
              count        <= '0;
              state        <= S_CRST;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        S_CRST: begin
          bus.s_ready <= 1'b1;
          state       <= S_LOAD;
        end
        S_LOAD: begin
          // s_ready low inside LOAD marks the final write cycle still in flight
          if (bus.s_ready) begin
            if (bus.s_valid) begin
              bus.core_wr <= 1'b1;
              bus.core_x  <= bus.s_data;
              bus.core_n  <= WIDTH'(count);
              count       <= count + 1'b1;
              if (last) bus.s_ready <= 1'b0;
            end
          end else begin
            timer <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.core_done) begin
            bus.res_re    <= WIDTH'($signed(bus.core_re) >>> FRAC_BITS);
            bus.res_im    <= WIDTH'($signed(bus.core_im) >>> FRAC_BITS);
            bus.res_valid <= 1'b1;
            state         <= S_HOLD;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dft_frame_driver.sv
// tb/tb_dft_frame_driver.sv - randomized scoreboard bench for dft_frame_driver
module tb_dft_frame_driver;
  localparam int W  = 16;
  localparam int FB = 6;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dft_frame_driver_if #(.WIDTH(W)) bus ();

  dft_frame_driver #(
    .WIDTH(W), .N_MAX(1024), .LOG_N_MAX(10), .FRAC_BITS(FB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct { int n; int x; } wr_t;

  int  vectors     = 0;
  int  miscompares = 0;
  wr_t exp_wr[$];
  int  exp_re[$];
  int  exp_im[$];
  int  src_q[$];
  int  valid_mode  = 0;

  task automatic check(string name, int got, int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // floor(v / 2^FB) from integer division
  function automatic int fl(int v);
    int q;
    q = v / (1 << FB);
    if (v < 0 && (v % (1 << FB)) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int rs16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  // upstream sample source
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (src_q.size() > 0) begin
        case (valid_mode)
          0:       bus.s_valid = 1'($urandom_range(0, 1));
          1:       bus.s_valid = ~bus.s_valid;
          default: bus.s_valid = 1'b1;
        endcase
        bus.s_data = W'(src_q[0]);
      end else begin
        bus.s_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.s_valid && bus.s_ready && src_q.size() > 0) void'(src_q.pop_front());
  end

  // monitor
  always @(negedge clk) begin
    if (bus.core_wr) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_wr", 1, 0);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_n", int'(bus.core_n), e.n);
        check("wr_x", int'($signed(bus.core_x)), e.x);
      end
    end
    if (bus.res_valid) begin
      if (exp_re.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else if (bus.res_ready) begin
        check("res_re", int'($signed(bus.res_re)), exp_re.pop_front());
        check("res_im", int'($signed(bus.res_im)), exp_im.pop_front());
      end
    end
  end

  task automatic check_zero(string tag);
    check({tag, "_wr"},    int'(bus.core_wr),   0);
    check({tag, "_ready"}, int'(bus.s_ready),   0);
    check({tag, "_busy"},  int'(bus.busy),      0);
    check({tag, "_valid"}, int'(bus.res_valid), 0);
    check({tag, "_crst"},  int'(bus.core_rst),  0);
    check({tag, "_err"},   int'(bus.err),       0);
    check({tag, "_n"},     int'(bus.core_n),    0);
    check({tag, "_x"},     int'(bus.core_x),    0);
    check({tag, "_k"},     int'(bus.core_k),    0);
    check({tag, "_len"},   int'(bus.core_len),  0);
    check({tag, "_re"},    int'(bus.res_re),    0);
  endtask

  task automatic pulse_start(int k, int len);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.start_k   = W'(k);
    bus.start_len = W'(len);
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic queue_samples(int len, bit fix_m1);
    for (int i = 0; i < len; i++) begin
      int s;
      s = fix_m1 ? -1 : rs16();
      src_q.push_back(s);
      exp_wr.push_back('{n: i, x: s});
    end
  endtask

  task automatic run_frame(int k, int len, int vmode, bit fix_m1, bit respond,
                           int delay, int re, int im, int hold, bit start_at_hs);
    int t;
    valid_mode = vmode;
    queue_samples(len, fix_m1);
    pulse_start(k, len);
    @(negedge clk);
    check("core_rst_pulse", int'(bus.core_rst), 1);
    check("busy_after_start", int'(bus.busy), 1);
    check("core_k", int'(bus.core_k), k & 16'hffff);
    check("core_len", int'(bus.core_len), len);
    t = 0;
    while (exp_wr.size() > 0 && t < 5000) begin
      @(negedge clk); #1;
      t++;
    end
    check("load_drained", exp_wr.size(), 0);
    if (respond) begin
      repeat (delay) @(posedge clk);
      @(posedge clk); #1;
      bus.core_done = 1'b1;
      bus.core_re   = W'(re);
      bus.core_im   = W'(im);
      exp_re.push_back(fl(re));
      exp_im.push_back(fl(im));
      @(posedge clk); #1;
      bus.core_done = 1'b0;
      bus.core_re   = W'(rs16());
      bus.core_im   = W'(rs16());
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("valid_hold", int'(bus.res_valid), 1);
        check("hold_re", int'($signed(bus.res_re)), fl(re));
      end
      @(posedge clk); #1;
      bus.res_ready = 1'b1;
      if (start_at_hs) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      bus.start     = 1'b0;
      @(negedge clk);
      check("valid_cleared", int'(bus.res_valid), 0);
      check("result_consumed", exp_re.size(), 0);
      @(negedge clk);
      check("idle_busy", int'(bus.busy), 0);
      check("idle_no_crst", int'(bus.core_rst), 0);
      check("k_stable", int'(bus.core_k), k & 16'hffff);
    end else begin
      int found;
      found = 0;
      bus.res_ready = 1'b1;
      for (int i = 1; i <= TO + 10 && found == 0; i++) begin
        @(negedge clk);
        if (bus.err) found = i;
      end
      check("timeout_cycles", found, TO + 1);
      check("timeout_busy", int'(bus.busy), 0);
      @(negedge clk);
      check("timeout_err_pulse", int'(bus.err), 0);
      bus.res_ready = 1'b0;
    end
  endtask

  task automatic bad_start(int len);
    pulse_start(3, len);
    @(negedge clk);
    check("bad_err", int'(bus.err), 1);
    check("bad_busy", int'(bus.busy), 0);
    check("bad_crst", int'(bus.core_rst), 0);
    @(negedge clk);
    check("bad_err_clear", int'(bus.err), 0);
    check("bad_busy2", int'(bus.busy), 0);
  endtask

  task automatic idle_done_pulse();
    @(posedge clk); #1;
    bus.core_done = 1'b1;
    bus.core_re   = W'(rs16());
    @(posedge clk); #1;
    bus.core_done = 1'b0;
    @(negedge clk);
    check("idle_done_ignored", int'(bus.res_valid), 0);
  endtask

  initial begin
    int t;
    bus.start     = 1'b0;
    bus.start_k   = '0;
    bus.start_len = '0;
    bus.core_re   = '0;
    bus.core_im   = '0;
    bus.core_done = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame(0, 2, 2, 1'b1, 1'b1, 0, -128, 0, 2, 1'b0);
    run_frame(3, 4, 1, 1'b0, 1'b1, 2, rs16(), rs16(), 0, 1'b0);
    bad_start(0);
    bad_start(1025);
    bad_start(65535);
    run_frame(1, 3, 0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);

    // reset lands right after the first of four writes
    valid_mode = 2;
    queue_samples(4, 1'b0);
    pulse_start(7, 4);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.core_wr && t < 50);
    check("reset_test_first_wr", int'(bus.core_wr), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_wr.delete();
    src_q.delete();
    @(negedge clk);
    check_zero("midload_reset");
    run_frame(5, 4, 0, 1'b0, 1'b1, 3, rs16(), rs16(), 1, 1'b0);

    run_frame(2, 5, 0, 1'b0, 1'b1, 1, -65, rs16(), 5, 1'b1);
    run_frame(9, 1, 2, 1'b0, 1'b1, 0, 63, -1, 0, 1'b0);
    idle_done_pulse();
    run_frame(4, 1024, 2, 1'b0, 1'b1, 4, rs16(), rs16(), 1, 1'b0);

    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 3) == 0) idle_done_pulse();
      run_frame(rs16(), $urandom_range(1, 12), $urandom_range(0, 2), 1'b0, 1'b1,
                $urandom_range(0, 10), rs16(), rs16(), $urandom_range(0, 4),
                1'($urandom_range(0, 1)));
    end

    check("final_wr_queue", exp_wr.size(), 0);
    check("final_res_queue", exp_re.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end
endmodule
